// File: rtl/intg_wf_gen_if.sv
// Output bundle of intg_wf_gen: serial waveform plus optional status.
// INTG_STATUS_EN adds the pre_q/sel_q/frame_start status signals.
`ifdef INTG_STATUS_EN
interface intg_wf_gen_if #(
    parameter int PRE_W = 3,
    parameter int SEL_W = 4
);
    logic             wf;
    logic [PRE_W-1:0] pre_q;
    logic [SEL_W-1:0] sel_q;
    logic             frame_start;

    modport master (
        output wf,
        output pre_q,
        output sel_q,
        output frame_start
    );

    modport slave (
        input wf,
        input pre_q,
        input sel_q,
        input frame_start
    );
endinterface
`else
interface intg_wf_gen_if;
    logic wf;

    modport master (
        output wf
    );

    modport slave (
        input wf
    );
endinterface
`endif

// File: rtl/intg_wf_gen.sv
// Serial waveform generator: prescaled select counter muxes a pattern word.
// INTG_STATUS_EN exposes the counters and a frame-start flag on the bus.
module intg_wf_gen #(
    parameter int                     PRE_W   = 3,
    parameter int                     SEL_W   = 4,
    parameter logic [2**SEL_W-1:0]    PATTERN = 16'h3C96
) (
    input  logic          clock,
    input  logic          clear,
    intg_wf_gen_if.master bus
);

    localparam logic [PRE_W-1:0] PRE_MAX = '1;

    logic [PRE_W-1:0] pre;
    logic [SEL_W-1:0] sel;

    // Clear wins over every increment, including the wrap edge.
    always_ff @(posedge clock) begin
        if (clear) begin
            pre <= '0;
            sel <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
            if (pre == PRE_MAX) begin
                sel <= sel + SEL_W'(1);
            end
        end
    end

    assign bus.wf = PATTERN[sel];

`ifdef INTG_STATUS_EN
    assign bus.pre_q       = pre;
    assign bus.sel_q       = sel;
    assign bus.frame_start = (pre == '0) && (sel == '0);
`endif

endmodule

// File: tb/tb_intg_wf_gen.sv
// Self-checking bench for intg_wf_gen: default build plus a small override.
// Reference model counts edges since clear and indexes the pattern.
module tb_intg_wf_gen;

    localparam logic [15:0] PAT0 = 16'h3C96;
    localparam logic [3:0]  PAT1 = 4'b1010;

    logic clock = 1'b0;
    logic clr0  = 1'b1;
    logic clr1  = 1'b1;

    int checks = 0;
    int errors = 0;
    int n0 = 0;
    int n1 = 0;

    logic [15:0] pat0 = PAT0;
    logic [3:0]  pat1 = PAT1;

    always #5 clock = ~clock;

`ifdef INTG_STATUS_EN
    intg_wf_gen_if #(.PRE_W(3), .SEL_W(4)) b0 ();
    intg_wf_gen_if #(.PRE_W(1), .SEL_W(2)) b1 ();
`else
    intg_wf_gen_if b0 ();
    intg_wf_gen_if b1 ();
`endif

    intg_wf_gen d0 (
        .clock (clock),
        .clear (clr0),
        .bus   (b0)
    );

    intg_wf_gen #(
        .PRE_W   (1),
        .SEL_W   (2),
        .PATTERN (4'b1010)
    ) d1 (
        .clock (clock),
        .clear (clr1),
        .bus   (b1)
    );

    // Drive clears, take one edge, advance the edge-count models.
    task automatic step(input logic c0, input logic c1);
        clr0 = c0;
        clr1 = c1;
        @(posedge clock);
        n0 = c0 ? 0 : n0 + 1;
        n1 = c1 ? 0 : n1 + 1;
        #1;
    endtask

    function automatic logic exp0(input int n);
        return pat0[(n / 8) % 16];
    endfunction

    function automatic logic exp1(input int n);
        return pat1[(n / 2) % 4];
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (b0.wf !== 1'b0) begin
                errors++;
                $display("FAIL reset_wf0 cyc %0d: got %b want 0", i, b0.wf);
            end
            checks++;
            if (b1.wf !== 1'b0) begin
                errors++;
                $display("FAIL reset_wf1 cyc %0d: got %b want 0", i, b1.wf);
            end
`ifdef INTG_STATUS_EN
            checks++;
            if (b0.pre_q !== 3'd0 || b0.sel_q !== 4'd0 ||
                b0.frame_start !== 1'b1) begin
                errors++;
                $display("FAIL reset_status: pre %0d sel %0d fs %b want 0 0 1",
                         b0.pre_q, b0.sel_q, b0.frame_start);
            end
`endif
        end
    endtask

    task automatic test_frames();
        logic runs [16];
        runs = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0};
        for (int k = 1; k <= 256; k++) begin
            step(1'b0, 1'b1);
            checks++;
            if (b0.wf !== runs[(k / 8) % 16]) begin
                errors++;
                $display("FAIL frame_wf clk %0d: got %b want %b",
                         k, b0.wf, runs[(k / 8) % 16]);
            end
`ifdef INTG_STATUS_EN
            checks++;
            if (b0.frame_start !== ((k % 128) == 0)) begin
                errors++;
                $display("FAIL frame_start clk %0d: got %b want %b",
                         k, b0.frame_start, (k % 128) == 0);
            end
            checks++;
            if (b0.sel_q !== 4'((k / 8) % 16) || b0.pre_q !== 3'(k % 8)) begin
                errors++;
                $display("FAIL frame_status clk %0d: sel %0d pre %0d want %0d %0d",
                         k, b0.sel_q, b0.pre_q, (k / 8) % 16, k % 8);
            end
`endif
        end
    endtask

    task automatic test_clear_mid_bit();
        for (int i = 0; i < 200 && (n0 % 128) != 43; i++) begin
            step(1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        checks++;
        if (b0.wf !== 1'b0) begin
            errors++;
            $display("FAIL midbit_clear_wf: got %b want 0", b0.wf);
        end
`ifdef INTG_STATUS_EN
        checks++;
        if (b0.sel_q !== 4'd0 || b0.pre_q !== 3'd0) begin
            errors++;
            $display("FAIL midbit_clear_status: sel %0d pre %0d want 0 0",
                     b0.sel_q, b0.pre_q);
        end
`endif
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 1'b0);
            checks++;
            if (b0.wf !== (e == 8)) begin
                errors++;
                $display("FAIL midbit_restart edge %0d: got %b want %b",
                         e, b0.wf, e == 8);
            end
        end
    endtask

    task automatic test_clear_on_wrap();
        // pre=7, sel=1: without clear the next bit would be PATTERN[2]=1
        step(1'b1, 1'b0);
        for (int i = 0; i < 200 && n0 != 15; i++) begin
            step(1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        checks++;
        if (b0.wf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_clear_wf: got %b want 0", b0.wf);
        end
        for (int i = 0; i < 300 && (n0 % 128) != 127; i++) begin
            step(1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        checks++;
        if (b0.wf !== 1'b0) begin
            errors++;
            $display("FAIL wrap15_clear_wf: got %b want 0", b0.wf);
        end
`ifdef INTG_STATUS_EN
        checks++;
        if (b0.sel_q !== 4'd0 || b0.pre_q !== 3'd0) begin
            errors++;
            $display("FAIL wrap15_clear_status: sel %0d pre %0d want 0 0",
                     b0.sel_q, b0.pre_q);
        end
`endif
    endtask

    task automatic test_param_override();
        logic seq [4];
        seq = '{0, 0, 1, 1};
        step(1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (b1.wf !== seq[k % 4]) begin
                errors++;
                $display("FAIL small_wf clk %0d: got %b want %b",
                         k, b1.wf, seq[k % 4]);
            end
        end
    endtask

    task automatic test_random();
        logic c0;
        logic c1;
        for (int i = 0; i < 2000; i++) begin
            c0 = ($urandom_range(0, 59) == 0);
            c1 = ($urandom_range(0, 29) == 0);
            step(c0, c1);
            checks++;
            if (b0.wf !== exp0(n0)) begin
                errors++;
                $display("FAIL rand_wf0 it %0d n %0d: got %b want %b",
                         i, n0, b0.wf, exp0(n0));
            end
            checks++;
            if (b1.wf !== exp1(n1)) begin
                errors++;
                $display("FAIL rand_wf1 it %0d n %0d: got %b want %b",
                         i, n1, b1.wf, exp1(n1));
            end
`ifdef INTG_STATUS_EN
            checks++;
            if (b0.sel_q !== 4'((n0 / 8) % 16) ||
                b0.frame_start !== ((n0 % 128) == 0)) begin
                errors++;
                $display("FAIL rand_status it %0d: sel %0d fs %b want %0d %b",
                         i, b0.sel_q, b0.frame_start,
                         (n0 / 8) % 16, (n0 % 128) == 0);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_clear_mid_bit();
        test_clear_on_wrap();
        test_param_override();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
